bus_cycle_gen: RTL and testbench

BUS_CYCLE_GEN -- requirements
Module: bus_cycle_gen

---
 rtl/pc_bus_pkg.sv | 40 ++++
 rtl/bus_wait_timer.sv | 29 ++
 rtl/bus_cycle_gen.sv | 152 +++++++++++++++
 tb/tb_bus_cycle_gen.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_bus_pkg.sv
// Shared 8088 bus definitions: status codes, bus-cycle states, wait timeout limit.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package pc_bus_pkg;

  // 8088 status codes driven on s_n during T1/T2
  localparam logic [2:0] STS_INTA = 3'b000;
  localparam logic [2:0] STS_IOR  = 3'b001;
  localparam logic [2:0] STS_IOW  = 3'b010;
  localparam logic [2:0] STS_RSVD = 3'b011;
  localparam logic [2:0] STS_CODE = 3'b100;
  localparam logic [2:0] STS_MEMR = 3'b101;
  localparam logic [2:0] STS_MEMW = 3'b110;
  localparam logic [2:0] STS_PASV = 3'b111;

  // Bus-cycle states; TH is the bus-hold state
  typedef enum logic [2:0] {
    ST_TI = 3'd0,
    ST_T1 = 3'd1,
    ST_T2 = 3'd2,
    ST_T3 = 3'd3,
    ST_TW = 3'd4,
    ST_T4 = 3'd5,
    ST_TH = 3'd6
  } bus_state_e;

  // Number of consecutive wait states tolerated before a forced T4
  localparam int unsigned WAIT_TIMEOUT = 16;

  // Codes that drive write data onto the AD bus after T1
  function automatic logic is_write(input logic [2:0] code);
    return (code == STS_IOW) || (code == STS_MEMW);
  endfunction

  // Codes that never start a bus cycle and are answered with an error
  function automatic logic is_bad(input logic [2:0] code);
    return (code == STS_RSVD) || (code == STS_PASV);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive TW cycles and flags the last one allowed before a forced T4.
// Latency: expired is combinational on the 16th consecutive TW cycle.
// Backpressure: none; any non-TW cycle restarts the count.
module bus_wait_timer
  import pc_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_tw,
  output logic expired
);

  localparam logic [3:0] LAST_TW = 4'(WAIT_TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;

  // Advance while waiting, restart otherwise; flag the final permitted wait state
  always_comb begin
    cnt_d   = in_tw ? cnt_q + 4'd1 : 4'd0;
    expired = in_tw && (cnt_q == LAST_TW);
  end

  // Wait-state counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_cycle_gen.sv
// 8088-style bus cycle generator: T1..T4 with wait states, INTA pairs and bus hold.
// Latency: accept at N, T1..T4 at N+1..N+4, rsp_valid at N+4 (+1 per TW); bad types answer at N+1.
// Backpressure: req_ready only in TI/T4 with no hold request and no INTA pair in flight.
// Optional: define BUS_WAIT_TIMEOUT_EN to force T4 with an error after 16 consecutive TW cycles.
module bus_cycle_gen
  import pc_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  s_n,
  output logic [11:0] a_hi,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  input  logic        ready,
  input  logic        hold_req,
  output logic        hold_ack
);

  bus_state_e  state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        inta_ph_q, inta_ph_d;   // second INTA cycle outstanding
  logic        inta_gap_q, inta_gap_d; // first of the two idle cycles between INTA halves seen
  logic        tmo_q, tmo_d;           // current T4 was forced by the wait timeout
  logic        bad_rsp_q, bad_rsp_d;   // error answer for an unsupported type

  logic busy, in_wait, cur_wr, inta_pending, accept, t4_rsp, wait_expired;

`ifdef BUS_WAIT_TIMEOUT_EN
  bus_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .in_tw   (state_q == ST_TW),
    .expired (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  // Phase decode and request handshake
  always_comb begin
    busy         = state_q inside {ST_T1, ST_T2, ST_T3, ST_TW, ST_T4};
    in_wait      = (state_q == ST_T3) || (state_q == ST_TW);
    cur_wr       = is_write(type_q);
    inta_pending = inta_ph_q || (busy && (type_q == STS_INTA));
    req_ready    = ((state_q == ST_TI) || (state_q == ST_T4)) && !hold_req && !inta_pending;
    accept       = req_valid && req_ready;
  end

  // Next-state sequencing; hold is only honoured from TI between whole cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TI: begin
        if (inta_ph_q) begin
          if (inta_gap_q) state_d = ST_T1;
        end else if (hold_req) begin
          state_d = ST_TH;
        end else if (accept && !is_bad(req_type)) begin
          state_d = ST_T1;
        end
      end
      ST_T1:        state_d = ST_T2;
      ST_T2:        state_d = ST_T3;
      ST_T3, ST_TW: state_d = (ready || wait_expired) ? ST_T4 : ST_TW;
      ST_T4:        state_d = (accept && !is_bad(req_type)) ? ST_T1 : ST_TI;
      ST_TH:        if (!hold_req) state_d = ST_TI;
      default:      state_d = ST_TI;
    endcase
  end

  // Request latches, read capture, INTA pairing and timeout bookkeeping
  always_comb begin
    type_d     = accept ? req_type  : type_q;
    addr_d     = accept ? req_addr  : addr_q;
    wdata_d    = accept ? req_wdata : wdata_q;
    rdata_d    = (in_wait && ready) ? ad_in : rdata_q;
    bad_rsp_d  = accept && is_bad(req_type);
    inta_gap_d = ((state_q == ST_TI) && inta_ph_q) ? !inta_gap_q : 1'b0;

    inta_ph_d = inta_ph_q;
    if ((state_q == ST_T4) && (type_q == STS_INTA)) begin
      // A timed-out first half abandons the pair instead of running the second half
      inta_ph_d = !inta_ph_q && !tmo_q;
    end

    if (in_wait)                tmo_d = !ready && wait_expired;
    else if (state_q == ST_T4)  tmo_d = tmo_q;
    else                        tmo_d = 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_TI;
      type_q     <= STS_PASV;
      addr_q     <= 20'h0;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      inta_ph_q  <= 1'b0;
      inta_gap_q <= 1'b0;
      tmo_q      <= 1'b0;
      bad_rsp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      inta_ph_q  <= inta_ph_d;
      inta_gap_q <= inta_gap_d;
      tmo_q      <= tmo_d;
      bad_rsp_q  <= bad_rsp_d;
    end
  end

  // Bus pins and response, decoded from the current state
  always_comb begin
    s_n      = ((state_q == ST_T1) || (state_q == ST_T2)) ? type_q : STS_PASV;
    a_hi     = busy ? addr_q[19:8] : 12'h000;
    hold_ack = (state_q == ST_TH);
    ad_oe    = 1'b0;
    ad_out   = 8'h00;
    if (state_q == ST_T1) begin
      ad_oe  = 1'b1;
      ad_out = addr_q[7:0];
    end else if (busy && cur_wr) begin
      ad_oe  = 1'b1;
      ad_out = wdata_q;
    end

    // The first INTA half completes silently unless it was cut short by the timeout
    t4_rsp    = (state_q == ST_T4) && !((type_q == STS_INTA) && !inta_ph_q && !tmo_q);
    rsp_valid = t4_rsp || bad_rsp_q;
    rsp_err   = bad_rsp_q || (t4_rsp && tmo_q);
    if (bad_rsp_q || (t4_rsp && tmo_q)) rsp_rdata = 8'hFF;
    else if (t4_rsp && !cur_wr)         rsp_rdata = rdata_q;
    else                                rsp_rdata = 8'h00;
  end

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Self-checking bench for bus_cycle_gen; responses are scored against a queue of expectations.
// Stimulus is driven 1 time unit after each rising edge and checked at the same point.
// The timeout scenario is compiled in only when BUS_WAIT_TIMEOUT_EN is defined.
module tb_bus_cycle_gen;

  localparam logic [2:0] C_INTA = 3'b000;
  localparam logic [2:0] C_IOR  = 3'b001;
  localparam logic [2:0] C_IOW  = 3'b010;
  localparam logic [2:0] C_RSVD = 3'b011;
  localparam logic [2:0] C_CODE = 3'b100;
  localparam logic [2:0] C_MEMR = 3'b101;
  localparam logic [2:0] C_MEMW = 3'b110;
  localparam logic [2:0] C_PASV = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [2:0]  s_n;
  logic [11:0] a_hi;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;
  logic        ready;
  logic        hold_req;
  logic        hold_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] exp_q[$];   // {rsp_err, rsp_rdata}
  logic [8:0] mon_exp;

  bus_cycle_gen dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .s_n       (s_n),
    .a_hi      (a_hi),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .ready     (ready),
    .hold_req  (hold_req),
    .hold_ack  (hold_ack)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rsp_unexpected got err=%b rdata=%h required no response", rsp_err, rsp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_exp) begin
          tests_failed++;
          $display("FAIL rsp_score got err=%b rdata=%h required err=%b rdata=%h",
                   rsp_err, rsp_rdata, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns at the cycle after acceptance
  task automatic send_req(input logic [2:0] t, input logic [19:0] a, input logic [7:0] w,
                          input logic push, input logic e_err, input logic [7:0] e_rd,
                          output int waited);
    waited    = 0;
    req_type  = t;
    req_addr  = a;
    req_wdata = w;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    if (req_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout got req_ready=%b required 1 within 40 cycles", req_ready);
    end else if (push) begin
      exp_q.push_back({e_err, e_rd});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if ({s_n, ad_oe, a_hi, ad_out} !== {3'b111, 1'b0, 12'h000, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_bus got s_n=%b oe=%b a_hi=%h ad=%h required 111 0 000 00", s_n, ad_oe, a_hi, ad_out);
    end
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_rdata, hold_ack} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_rsp got v=%b e=%b d=%h hack=%b required 0 0 00 0", rsp_valid, rsp_err, rsp_rdata, hold_ack);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got %b required 1", req_ready);
    end
  endtask

  task automatic test_mem_read();
    int w;
    logic [2:0]  e_sn [1:5];
    logic        e_oe [1:5];
    logic [7:0]  e_ad [1:5];
    logic [11:0] e_ah [1:5];
    logic        e_v  [1:5];
    e_sn = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b111};
    e_oe = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_ad = '{8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
    e_ah = '{12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'h000};
    e_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ready = 1'b1;
    ad_in = 8'h5A;
    send_req(C_MEMR, 20'hABCDE, 8'h00, 1'b1, 1'b0, 8'h5A, w);
    for (int k = 1; k <= 5; k++) begin
      tests_run++;
      if ({s_n, ad_oe, ad_out, a_hi, rsp_valid} !== {e_sn[k], e_oe[k], e_ad[k], e_ah[k], e_v[k]}) begin
        tests_failed++;
        $display("FAIL memrd_cycle%0d got s_n=%b oe=%b ad=%h a_hi=%h v=%b required %b %b %h %h %b", k,
                 s_n, ad_oe, ad_out, a_hi, rsp_valid, e_sn[k], e_oe[k], e_ad[k], e_ah[k], e_v[k]);
      end
      if (k == 4) begin
        tests_run++;
        if (rsp_rdata !== 8'h5A) begin
          tests_failed++;
          $display("FAIL memrd_rdata got %h required 5a", rsp_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_io_write_wait();
    int w;
    logic [2:0] e_sn [1:7];
    logic [7:0] e_ad [1:7];
    e_sn = '{3'b010, 3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    e_ad = '{8'hF8, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
    send_req(C_IOW, 20'h003F8, 8'hC3, 1'b1, 1'b0, 8'h00, w);
    ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tests_run++;
      if ({s_n, ad_oe, ad_out, a_hi, rsp_valid} !== {e_sn[k], 1'b1, e_ad[k], 12'h003, (k == 7)}) begin
        tests_failed++;
        $display("FAIL iowr_cycle%0d got s_n=%b oe=%b ad=%h a_hi=%h v=%b required %b 1 %h 003 %b", k,
                 s_n, ad_oe, ad_out, a_hi, rsp_valid, e_sn[k], e_ad[k], (k == 7));
      end
      if (k == 6) ready = 1'b1;
      tick();
    end
    tests_run++;
    if (ad_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL iowr_release got oe=%b required 0", ad_oe);
    end
  endtask

  task automatic test_inta();
    int w;
    logic [2:0] e_sn [1:10];
    e_sn = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111};
    ready = 1'b1;
    ad_in = 8'h11;
    send_req(C_INTA, 20'h00000, 8'h00, 1'b1, 1'b0, 8'h08, w);
    for (int k = 1; k <= 10; k++) begin
      tests_run++;
      if ({s_n, rsp_valid, req_ready} !== {e_sn[k], (k == 10), 1'b0}) begin
        tests_failed++;
        $display("FAIL inta_cycle%0d got s_n=%b v=%b rdy=%b required %b %b 0", k,
                 s_n, rsp_valid, req_ready, e_sn[k], (k == 10));
      end
      if (k == 4) ad_in = 8'h08;
      tick();
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL inta_ready_after got %b required 1", req_ready);
    end
  endtask

  task automatic test_hold();
    int w;
    ready = 1'b1;
    send_req(C_MEMW, 20'h12345, 8'h77, 1'b1, 1'b0, 8'h00, w);
    tick();                       // T2
    hold_req = 1'b1;
    tick(); tick();               // T4
    tests_run++;
    if ({rsp_valid, req_ready, hold_ack, ad_out} !== {1'b1, 1'b0, 1'b0, 8'h77}) begin
      tests_failed++;
      $display("FAIL hold_write_done got v=%b rdy=%b hack=%b ad=%h required 1 0 0 77", rsp_valid, req_ready, hold_ack, ad_out);
    end
    tick();                       // TI
    tests_run++;
    if ({hold_ack, s_n} !== {1'b0, 3'b111}) begin
      tests_failed++;
      $display("FAIL hold_ti got hack=%b s_n=%b required 0 111", hold_ack, s_n);
    end
    req_type  = C_MEMR;
    req_addr  = 20'h0F00F;
    req_valid = 1'b1;
    ad_in     = 8'h3C;
    exp_q.push_back({1'b0, 8'h3C});
    tick();                       // TH
    tests_run++;
    if ({hold_ack, ad_oe, s_n, a_hi, req_ready} !== {1'b1, 1'b0, 3'b111, 12'h000, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_th got hack=%b oe=%b s_n=%b a_hi=%h rdy=%b required 1 0 111 000 0",
               hold_ack, ad_oe, s_n, a_hi, req_ready);
    end
    tick();
    hold_req = 1'b0;
    tick();                       // TI
    tests_run++;
    if ({hold_ack, req_ready} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL hold_exit got hack=%b rdy=%b required 0 1", hold_ack, req_ready);
    end
    tick();                       // T1 of the queued read
    req_valid = 1'b0;
    tests_run++;
    if ({s_n, a_hi} !== {3'b101, 12'h0F0}) begin
      tests_failed++;
      $display("FAIL hold_queued_t1 got s_n=%b a_hi=%h required 101 0f0", s_n, a_hi);
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_bad_type();
    int w;
    logic [2:0] codes [0:1];
    codes = '{C_RSVD, C_PASV};
    for (int i = 0; i < 2; i++) begin
      send_req(codes[i], 20'h55555, 8'h00, 1'b1, 1'b1, 8'hFF, w);
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_rdata, s_n, ad_oe, a_hi} !== {1'b1, 1'b1, 8'hFF, 3'b111, 1'b0, 12'h000}) begin
        tests_failed++;
        $display("FAIL bad_type_%b got v=%b e=%b d=%h s_n=%b oe=%b a_hi=%h required 1 1 ff 111 0 000",
                 codes[i], rsp_valid, rsp_err, rsp_rdata, s_n, ad_oe, a_hi);
      end
      tick();
      tests_run++;
      if ({rsp_valid, s_n} !== {1'b0, 3'b111}) begin
        tests_failed++;
        $display("FAIL bad_type_after_%b got v=%b s_n=%b required 0 111", codes[i], rsp_valid, s_n);
      end
    end
  endtask

  task automatic test_reset_in_tw();
    int w;
    ready = 1'b0;
    send_req(C_MEMR, 20'h11111, 8'h00, 1'b0, 1'b0, 8'h00, w);
    tick(); tick(); tick();       // TW
    tests_run++;
    if (a_hi !== 12'h111) begin
      tests_failed++;
      $display("FAIL rst_tw_pre got a_hi=%h required 111", a_hi);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({rsp_valid, s_n, a_hi, ad_oe, hold_ack} !== {1'b0, 3'b111, 12'h000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_tw_abort got v=%b s_n=%b a_hi=%h oe=%b hack=%b required 0 111 000 0 0",
               rsp_valid, s_n, a_hi, ad_oe, hold_ack);
    end
    rst   = 1'b0;
    ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_tw_ready got %b required 1", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_tw_quiet%0d got v=%b required 0", k, rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [2:0]  t  [0:2];
    logic [19:0] a  [0:2];
    logic [7:0]  di [0:2];
    logic [7:0]  er [0:2];
    t  = '{C_IOR, C_CODE, C_MEMW};
    a  = '{20'h00310, 20'hF0000, 20'h20000};
    di = '{8'h66, 8'h99, 8'hEE};
    er = '{8'h66, 8'h99, 8'h00};
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_req(t[i], a[i], 8'h55, 1'b1, 1'b0, er[i], w);
      tests_run++;
      if ({s_n, w} !== {t[i], ((i == 0) ? 32'd0 : 32'd1)}) begin
        tests_failed++;
        $display("FAIL b2b_t1_%0d got s_n=%b waited=%0d required %b %0d", i, s_n, w, t[i], (i == 0) ? 0 : 1);
      end
      ad_in = di[i];
      tick(); tick();             // T3
    end
    tick(); tick();
  endtask

`ifdef BUS_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int n;
    ready = 1'b0;
    send_req(C_MEMR, 20'h2468A, 8'h00, 1'b1, 1'b1, 8'hFF, w);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if ({n, rsp_err, rsp_rdata} !== {32'd20, 1'b1, 8'hFF}) begin
      tests_failed++;
      $display("FAIL timeout_t4 got cycle=%0d e=%b d=%h required 20 1 ff", n, rsp_err, rsp_rdata);
    end
    ready = 1'b1;
    tick(); tick();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_type  = 3'b000;
    req_addr  = 20'h0;
    req_wdata = 8'h00;
    ad_in     = 8'h00;
    ready     = 1'b1;
    hold_req  = 1'b0;
    test_reset();
    test_mem_read();
    test_io_write_wait();
    test_inta();
    test_hold();
    test_bad_type();
    test_reset_in_tw();
    test_back_to_back();
`ifdef BUS_WAIT_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
